// File: rtl/rsa_timing_probe.sv
// rsa_timing_probe: measures start-to-finish latency of each RSA decrypt and queues
// {latency, ciphertext tag, saturated} samples in a small FIFO for a valid/ready reader.
module rsa_timing_probe #(
  parameter int CNT_WIDTH  = 16,
  parameter int TAG_WIDTH  = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 finish,
  input  logic [TAG_WIDTH-1:0] tag,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [TAG_WIDTH-1:0] rd_tag,
  output logic                 rd_sat,
  output logic                 busy,
  output logic [7:0]           drop_cnt,
  output logic                 seq_err
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int EW    = CNT_WIDTH + TAG_WIDTH + 1;
  typedef enum logic {IDLE, MEASURE} state_t;
  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  sat_q, sat_d;
  logic                  seq_q, seq_d;
  logic [7:0]            drop_q, drop_d;
  logic [DEPTH_LOG2:0]   wr_q, wr_d, rd_q, rd_d;
  logic [EW-1:0]         mem_q [DEPTH];
  logic [EW-1:0]         mem_d [DEPTH];
  logic                  empty, full, push, pop;
  logic [EW-1:0]         head;
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[DEPTH_LOG2] != rd_q[DEPTH_LOG2]) &&
                 (wr_q[DEPTH_LOG2-1:0] == rd_q[DEPTH_LOG2-1:0]);
  assign push  = (state_q == MEASURE) && finish;
  assign pop   = !empty && rd_ready;
  // Head is masked while empty so stale entries never leak onto the read port.
  assign head     = empty ? '0 : mem_q[rd_q[DEPTH_LOG2-1:0]];
  assign rd_valid = !empty;
  assign rd_count = head[EW-1 -: CNT_WIDTH];
  assign rd_tag   = head[TAG_WIDTH:1];
  assign rd_sat   = head[0];
  assign busy     = state_q == MEASURE;
  assign drop_cnt = drop_q;
  assign seq_err  = seq_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    sat_d   = sat_q;
    seq_d   = seq_q;
    drop_d  = drop_q;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q + (DEPTH_LOG2+1)'(pop);
    if (state_q == IDLE) begin
      seq_d = seq_q | finish;
      if (start) begin
        state_d = MEASURE;
        cnt_d   = CNT_WIDTH'(1);
        tag_d   = tag;
        sat_d   = 1'b0;
      end
    end else if (finish) begin
      state_d = start ? MEASURE : IDLE;
      cnt_d   = start ? CNT_WIDTH'(1) : cnt_q;
      tag_d   = start ? tag : tag_q;
      sat_d   = start ? 1'b0 : sat_q;
    end else begin
      cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_WIDTH'(1);
      sat_d = sat_q | (&cnt_q);
      seq_d = seq_q | start;
    end
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    if (push && (!full || pop)) begin
      mem_d[wr_q[DEPTH_LOG2-1:0]] = {cnt_q, tag_q, sat_q};
      wr_d = wr_q + (DEPTH_LOG2+1)'(1);
    end else if (push) begin
      drop_d = drop_q + 8'(drop_q != 8'hff);
    end
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      tag_d   = '0;
      sat_d   = 1'b0;
      seq_d   = 1'b0;
      drop_d  = '0;
      wr_d    = '0;
      rd_d    = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      sat_q   <= 1'b0;
      seq_q   <= 1'b0;
      drop_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      sat_q   <= sat_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: tb/tb_rsa_timing_probe.sv
// tb_rsa_timing_probe: scoreboard bench driving a 16-bit and a 4-bit counter instance
// with the same stimulus; expected samples are queued at each finish and checked at the head.
module tb_rsa_timing_probe;
  logic        clk = 0, rst = 1, clr = 0, start = 0, finish = 0, rd_ready = 0;
  logic [15:0] tag = '0;
  logic        rd_valid, rd_sat, busy, seq_err;
  logic [15:0] rd_count, rd_tag;
  logic [7:0]  drop_cnt;
  logic        n_valid, n_sat, n_busy, n_seq;
  logic [3:0]  n_count;
  logic [15:0] n_tag;
  logic [7:0]  n_drop;
  int total = 0, bad = 0;

  rsa_timing_probe dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .finish(finish), .tag(tag),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_count(rd_count), .rd_tag(rd_tag),
    .rd_sat(rd_sat), .busy(busy), .drop_cnt(drop_cnt), .seq_err(seq_err));

  rsa_timing_probe #(.CNT_WIDTH(4)) dut_n (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .finish(finish), .tag(tag),
    .rd_valid(n_valid), .rd_ready(rd_ready), .rd_count(n_count), .rd_tag(n_tag),
    .rd_sat(n_sat), .busy(n_busy), .drop_cnt(n_drop), .seq_err(n_seq));

  always #5 clk = ~clk;

  task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tg, got, exp, $time);
    end
  endtask

  typedef struct {int c; logic [15:0] t;} smp_t;
  smp_t q[$];
  bit   ms = 0, mseq = 0;
  int   mc = 0, mdrop = 0;
  logic [15:0] mt = '0;

  // Behavioural reference: unbounded latency count, ideal 4-entry queue.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst || clr) begin
      q.delete(); ms = 0; mc = 0; mdrop = 0; mseq = 0;
    end else begin
      bit pop;
      pop = q.size() > 0 && rd_ready;
      if (pop) void'(q.pop_front());
      if (ms && finish) begin
        if (q.size() == 4) mdrop = (mdrop == 255) ? 255 : mdrop + 1;
        else q.push_back('{mc, mt});
      end
      if (!ms) begin
        if (finish) mseq = 1;
        if (start) begin ms = 1; mc = 1; mt = tag; end
      end else if (finish) begin
        if (start) begin mc = 1; mt = tag; end else ms = 0;
      end else begin
        mc++;
        if (start) mseq = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("busy", busy, ms);
      chk("seq_err", seq_err, mseq);
      chk("drop_cnt", drop_cnt, mdrop);
      chk("rd_valid", rd_valid, q.size() > 0);
      chk("n_rd_valid", n_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("rd_count", rd_count, q[0].c);
        chk("rd_tag", rd_tag, q[0].t);
        chk("rd_sat", rd_sat, 0);
        chk("n_rd_count", n_count, q[0].c > 15 ? 15 : q[0].c);
        chk("n_rd_tag", n_tag, q[0].t);
        chk("n_rd_sat", n_sat, q[0].c > 15);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic meas(input logic [15:0] t, input int n, input bit rdy_pulse);
    logic r;
    r = rd_ready;
    start = 1; tag = t; tick();
    start = 0;
    repeat (n - 1) tick();
    finish = 1;
    if (rdy_pulse) rd_ready = 1;
    tick();
    finish = 0; rd_ready = r;
    tick();
  endtask

  task automatic zeros(input string tg);
    chk({tg, "_valid"}, {rd_valid, n_valid}, 0);
    chk({tg, "_count"}, {rd_count, n_count}, 0);
    chk({tg, "_tag"}, {rd_tag, n_tag}, 0);
    chk({tg, "_flags"}, {rd_sat, busy, seq_err, n_sat, n_busy, n_seq}, 0);
    chk({tg, "_drop"}, {drop_cnt, n_drop}, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 zeros("rst_in");
    rst = 0;
    tick();
    zeros("reset");
    rd_ready = 1;
    meas(16'hBEEF, 37, 0);
    repeat (3) tick();
    meas(16'h1234, 20, 0);
    repeat (3) tick();
    meas(16'h0007, 15, 0);
    repeat (3) tick();
    rd_ready = 0;
    for (int i = 0; i < 6; i++) meas(16'hA000 + 16'(i), 3 + i, 0);
    chk("t3_drop", drop_cnt, 2);
    chk("t3_valid", rd_valid, 1);
    meas(16'hC0DE, 5, 1);
    chk("t4_drop", drop_cnt, 2);
    chk("t4_valid", rd_valid, 1);
    rd_ready = 1;
    repeat (6) tick();
    chk("t4_empty", rd_valid, 0);
    start = 1; tag = 16'h1111; tick();
    start = 0;
    repeat (9) tick();
    finish = 1; start = 1; tag = 16'h2222; tick();
    finish = 0; start = 0;
    repeat (6) tick();
    finish = 1; tick();
    finish = 0;
    repeat (3) tick();
    chk("t5_seq", seq_err, 0);
    finish = 1; tick();
    finish = 0; tick();
    chk("clr_pre_seq", seq_err, 1);
    clr = 1; tick();
    clr = 0; tick();
    chk("clr_seq", seq_err, 0);
    finish = 1; tick();
    finish = 0; tick();
    chk("t6_seq", seq_err, 1);
    start = 1; tag = 16'h5A5A; tick();
    start = 0;
    repeat (4) tick();
    chk("t6_busy", busy, 1);
    rst = 1; #1;
    zeros("t6_rst");
    tick();
    rst = 0;
    tick();
    zeros("t6_after");
    meas(16'h00AA, 4, 0);
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
